// File: rtl/spike_packet_scheduler.sv
// spike_packet_scheduler: latches cluster spikes, round-robin grants a neuron and streams one packet per downstream connection
module spike_packet_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W = 12,
  parameter int PTR_W = 5,
  parameter int MAX_CONN = 30
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spikes,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_sel,
  input  logic [PTR_W-1:0]       cfg_index,
  input  logic [ADDR_W-1:0]      cfg_data,
  output logic [2*ADDR_W-1:0]    packet,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic                   busy,
  output logic                   cfg_err
);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int PW = $clog2(NUM_NEURONS + 1);
  localparam int GW = NW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [PTR_W-1:0] MAXC = PTR_W'(MAX_CONN);
  localparam logic [PTR_W-1:0] NN = PTR_W'(NUM_NEURONS);
  localparam logic [NUM_NEURONS-1:0] ONE = NUM_NEURONS'(1);
  logic [ADDR_W-1:0] addr_tab [NUM_NEURONS];
  logic [PTR_W-1:0] ptr_tab [NUM_NEURONS+1];
  logic [ADDR_W-1:0] conn_tab [MAX_CONN];
  logic [0:0] state;
  logic [NUM_NEURONS-1:0] pending, rot, done_mask;
  logic [NW-1:0] rr_ptr, g_r, grant;
  logic [GW-1:0] gsum;
  logic [PTR_W-1:0] j_r, end_r, j_ld, nxt_p, end_ld, j_nxt;
  logic abort_r, found, has_conn, accept, more, drop_idle, drop_send, idx_ok, cfg_ok;

  function automatic logic [NW-1:0] wrap_inc(input logic [NW-1:0] x);
    return (x == NW'(NUM_NEURONS - 1)) ? '0 : x + 1'b1;
  endfunction

  // first pending neuron at or above rr_ptr, wrapping to 0
  always_comb begin
    rot = NUM_NEURONS'({pending, pending} >> rr_ptr);
    found = 1'b0;
    gsum = '0;
    for (int k = NUM_NEURONS - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        gsum = {1'b0, rr_ptr} + GW'(k);
      end
    grant = (gsum >= GW'(NUM_NEURONS)) ? NW'(gsum - GW'(NUM_NEURONS)) : NW'(gsum);
  end

  // connection range of the granted neuron; reversed pointers collapse to an empty range
  assign j_ld = ptr_tab[PW'(grant)];
  assign nxt_p = ptr_tab[PW'(grant) + PW'(1)];
  assign end_ld = (nxt_p > MAXC) ? MAXC : nxt_p;
  assign has_conn = j_ld < end_ld;
  assign j_nxt = j_r + 1'b1;
  assign accept = (state == SEND) && packet_ready;
  assign more = !clear && !abort_r && (j_nxt < end_r);
  assign drop_idle = (state == IDLE) && !clear && found && !has_conn;
  assign drop_send = accept && !clear && !abort_r && !(j_nxt < end_r);
  assign done_mask = drop_idle ? ONE << grant : drop_send ? ONE << g_r : '0;
  assign busy = (pending != '0) || (state != IDLE);

  // spike capture and the IDLE/SEND sequencer
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      rr_ptr <= '0;
      g_r <= '0;
      j_r <= '0;
      end_r <= '0;
      abort_r <= 1'b0;
      packet <= '0;
      packet_valid <= 1'b0;
    end else begin
      pending <= clear ? '0 : (pending | spikes) & ~done_mask;
      if (state == IDLE) begin
        if (!clear && found && has_conn) begin
          state <= SEND;
          g_r <= grant;
          j_r <= j_ld;
          end_r <= end_ld;
          abort_r <= 1'b0;
          packet <= {addr_tab[grant], conn_tab[j_ld]};
          packet_valid <= 1'b1;
        end else if (drop_idle)
          rr_ptr <= wrap_inc(grant);
      end else if (accept) begin
        if (more) begin
          j_r <= j_nxt;
          packet <= {addr_tab[g_r], conn_tab[j_nxt]};
        end else begin
          state <= IDLE;
          packet_valid <= 1'b0;
          abort_r <= 1'b0;
          rr_ptr <= wrap_inc(g_r);
        end
      end else if (clear)
        abort_r <= 1'b1;
    end
  end

  // config writes only land while fully quiet and in range
  always_comb begin
    idx_ok = (cfg_sel == 2'd0) ? cfg_index < NN :
             (cfg_sel == 2'd1) ? cfg_index <= NN :
             (cfg_sel == 2'd2) ? cfg_index < MAXC : 1'b0;
    cfg_ok = cfg_we && !busy && (spikes == '0) && idx_ok;
  end

  // table storage and the reject pulse
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) addr_tab[i] <= '0;
      for (int i = 0; i <= NUM_NEURONS; i++) ptr_tab[i] <= '0;
      for (int i = 0; i < MAX_CONN; i++) conn_tab[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok && cfg_sel == 2'd0) addr_tab[cfg_index[NW-1:0]] <= cfg_data;
      if (cfg_ok && cfg_sel == 2'd1) ptr_tab[cfg_index[PW-1:0]] <= cfg_data[PTR_W-1:0];
      if (cfg_ok && cfg_sel == 2'd2) conn_tab[cfg_index] <= cfg_data;
    end
  end
endmodule
